// File: rtl/player_health_controller.sv
// player_health_controller
// Turns collider hit events into player HP, invulnerability frames and death
// status, and reports the consumed bar width for the display stage.
// Optional feature: define PLAYER_KARMA_EN to split hit damage into 1 HP of
// immediate loss plus pending karma that drains every KR_TICKS game ticks.
// Without the macro, full damage applies at once and kr_amount is tied to 0.
//
// Handshake: there is no valid/ready pair; hit_pulse is the per-hit strobe,
// and every output is a register that updates on the edge after its cause.
module player_health_controller #(
  parameter int IS_SIM       = 0,
  parameter int TICK_DIV     = 1_000_000,
  parameter int TICK_DIV_SIM = 10,
  parameter int HP_RESET     = 92,
  parameter int INVULN_TICKS = 50,
  parameter int KR_TICKS     = 3
) (
  input  logic       clk,
  input  logic       clk_reset_n,
  input  logic       is_trigger_player,
  input  logic       reset_healt_status,
  input  logic [9:0] healt_bar_w,
  input  logic [6:0] healt_bar_sensitivity,
  output logic [9:0] hp,
  output logic [9:0] healt_bar_w_minus,
  output logic [9:0] kr_amount,
  output logic       hit_pulse,
  output logic       player_hurt,
  output logic       player_dead,
  output logic [1:0] state_dbg
);

  localparam int DIV = (IS_SIM != 0) ? TICK_DIV_SIM : TICK_DIV;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = $clog2(INVULN_TICKS + 1);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [9:0]    hp_q, hp_d, hp_new, minus_q, dmg;
  logic [IW-1:0] inv_q, inv_d;
  logic          pulse_q, pulse_d, hurt_q, dead_q, hit;

  assign dmg  = {3'b000, healt_bar_sensitivity};
  assign tick = (tick_cnt == CW'(DIV - 1));

  // Free-running game tick divider; reload pulses never touch it.
  always_ff @(posedge clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

`ifdef PLAYER_KARMA_EN
  localparam int KW = (KR_TICKS > 1) ? $clog2(KR_TICKS) : 1;
  logic [9:0]    kr_q, kr_d;
  logic [KW-1:0] drain_cnt;
  logic          drain_evt;
  logic [10:0]   kr_sum, kr_cap;

  assign drain_evt = tick && (drain_cnt == KW'(KR_TICKS - 1)) && (state_q != ST_DEAD);

  // Drain cadence counter: counts ticks while alive, restarts on reload.
  always_ff @(posedge clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      drain_cnt <= '0;
      kr_q      <= '0;
    end else begin
      kr_q <= kr_d;
      if (reset_healt_status) begin
        drain_cnt <= '0;
      end else if (tick && state_q != ST_DEAD) begin
        drain_cnt <= drain_evt ? '0 : drain_cnt + KW'(1);
      end
    end
  end

  assign kr_amount = kr_q;
`else
  assign kr_amount = '0;
`endif

  // Next-state, HP and invulnerability-counter decisions.
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    inv_d   = inv_q;
    pulse_d = 1'b0;
    hit     = 1'b0;
    hp_new  = hp_q;
`ifdef PLAYER_KARMA_EN
    kr_d    = kr_q;
    kr_sum  = {1'b0, kr_q} + {1'b0, dmg} - 11'd1;
    kr_cap  = '0;
`endif
    if (reset_healt_status) begin
      // Reload wins over any simultaneous hit.
      hp_d    = healt_bar_w;
      inv_d   = '0;
      state_d = (healt_bar_w == 10'd0) ? ST_DEAD : ST_ALIVE;
`ifdef PLAYER_KARMA_EN
      kr_d    = '0;
`endif
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (is_trigger_player) begin
            hit     = 1'b1;
            pulse_d = 1'b1;
`ifdef PLAYER_KARMA_EN
            // One HP now, the rest becomes karma capped so it cannot kill.
            if (dmg != 10'd0) begin
              hp_new = (hp_q > 10'd1) ? hp_q - 10'd1 : 10'd0;
              kr_cap = {1'b0, hp_new - 10'd1};
              if (hp_new == 10'd0) begin
                kr_d = '0;
              end else begin
                kr_d = (kr_sum > kr_cap) ? kr_cap[9:0] : kr_sum[9:0];
              end
            end
`else
            hp_new = (hp_q > dmg) ? hp_q - dmg : 10'd0;
`endif
            hp_d = hp_new;
            if (hp_new == 10'd0) begin
              state_d = ST_DEAD;
            end else begin
              state_d = ST_INVULN;
              inv_d   = IW'(INVULN_TICKS);
            end
          end
        end
        ST_INVULN: begin
          if (tick) begin
            if (inv_q <= IW'(1)) begin
              state_d = ST_ALIVE;
              inv_d   = '0;
            end else begin
              inv_d = inv_q - IW'(1);
            end
          end
        end
        ST_DEAD: begin
          state_d = ST_DEAD;
        end
        default: begin
          state_d = ST_ALIVE;
        end
      endcase
`ifdef PLAYER_KARMA_EN
      // Karma drain step; a hit in the same cycle takes precedence.
      if (drain_evt && !hit) begin
        if (hp_q == 10'd1) begin
          kr_d = '0;
        end else if (kr_q != 10'd0 && hp_q > 10'd1) begin
          hp_d = hp_q - 10'd1;
          kr_d = kr_q - 10'd1;
        end
      end
`endif
    end
  end

  // State and registered outputs; consumed width lags HP by one cycle.
  always_ff @(posedge clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      state_q <= ST_ALIVE;
      hp_q    <= 10'(HP_RESET);
      inv_q   <= '0;
      pulse_q <= 1'b0;
      hurt_q  <= 1'b0;
      dead_q  <= 1'b0;
      minus_q <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      inv_q   <= inv_d;
      pulse_q <= pulse_d;
      hurt_q  <= (state_d == ST_INVULN);
      dead_q  <= (state_d == ST_DEAD);
      minus_q <= (hp_q > healt_bar_w) ? 10'd0 : healt_bar_w - hp_q;
    end
  end

  assign hp                = hp_q;
  assign healt_bar_w_minus = minus_q;
  assign hit_pulse         = pulse_q;
  assign player_hurt       = hurt_q;
  assign player_dead       = dead_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_player_health_controller.sv
// Bench for player_health_controller: directed scenarios push the expected
// output snapshots; a monitor pops one whenever the observable outputs change.
module tb_player_health_controller;

  logic       clk = 1'b0;
  logic       clk_reset_n = 1'b0;
  logic       is_trigger_player = 1'b0;
  logic       reset_healt_status = 1'b0;
  logic [9:0] healt_bar_w = 10'd92;
  logic [6:0] healt_bar_sensitivity = 7'd10;
  logic [9:0] hp, healt_bar_w_minus, kr_amount;
  logic       hit_pulse, player_hurt, player_dead;
  logic [1:0] state_dbg;

  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] last_snap = 'x;
  logic prev_pulse = 1'b0;

  player_health_controller #(
    .IS_SIM(1), .TICK_DIV(1_000_000), .TICK_DIV_SIM(10), .HP_RESET(92),
    .INVULN_TICKS(20), .KR_TICKS(3)
  ) dut (
    .clk(clk), .clk_reset_n(clk_reset_n),
    .is_trigger_player(is_trigger_player),
    .reset_healt_status(reset_healt_status),
    .healt_bar_w(healt_bar_w),
    .healt_bar_sensitivity(healt_bar_sensitivity),
    .hp(hp), .healt_bar_w_minus(healt_bar_w_minus), .kr_amount(kr_amount),
    .hit_pulse(hit_pulse), .player_hurt(player_hurt),
    .player_dead(player_dead), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [32:0] snap(input int h, input int m, input int k,
                                       input logic p, input logic u, input logic d);
    snap = {10'(h), 10'(m), 10'(k), p, u, d};
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_snap(input int h, input int m, input int k,
                             input logic p, input logic u, input logic d);
    exp_q.push_back(snap(h, m, k, p, u, d));
  endtask

  task automatic reload(input int w);
    healt_bar_w = 10'(w);
    reset_healt_status = 1'b1;
    step(1);
    reset_healt_status = 1'b0;
  endtask

  task automatic trig(input int n);
    is_trigger_player = 1'b1;
    step(n);
    is_trigger_player = 1'b0;
  endtask

  // Monitor: compare on every change of the observable outputs.
  always @(negedge clk) begin
    logic [32:0] cur, e;
    if (mon_en) begin
      cur = {hp, healt_bar_w_minus, kr_amount, hit_pulse, player_hurt, player_dead};
      if (hit_pulse) begin
        tests++;
        if (prev_pulse) begin
          fails++;
          $display("FAIL pulse_twice got two consecutive hit_pulse cycles, required single");
        end
      end
      prev_pulse = hit_pulse;
      if (cur !== last_snap) begin
        last_snap = cur;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change got hp=%0d minus=%0d kr=%0d p/h/d=%b required no change",
                   cur[32:23], cur[22:13], cur[12:3], cur[2:0]);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            fails++;
            $display("FAIL snapshot got hp=%0d minus=%0d kr=%0d p/h/d=%b required hp=%0d minus=%0d kr=%0d p/h/d=%b",
                     cur[32:23], cur[22:13], cur[12:3], cur[2:0],
                     e[32:23], e[22:13], e[12:3], e[2:0]);
          end
        end
      end
    end
  end

  initial begin
    step(3);
    clk_reset_n = 1'b1;
    expect_snap(92, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    step(3);
`ifdef PLAYER_KARMA_EN
    // hp 20, dmg 6: 1 HP now, 5 karma, drained one per KR_TICKS ticks.
    expect_snap(20, 0, 0, 0, 0, 0);
    reload(20);
    step(2);
    healt_bar_sensitivity = 7'd6;
    expect_snap(19, 0, 5, 1, 1, 0);
    expect_snap(19, 1, 5, 0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      expect_snap(19 - i, i, 5 - i, 0, 1, 0);
      expect_snap(19 - i, i + 1, 5 - i, 0, 1, 0);
    end
    expect_snap(14, 6, 0, 0, 0, 0);
    trig(1);
    step(240);
    // hp 3, dmg 10: karma capped so the drain stops at hp 1.
    expect_snap(3, 0, 0, 0, 0, 0);
    reload(3);
    step(2);
    healt_bar_sensitivity = 7'd10;
    expect_snap(2, 0, 1, 1, 1, 0);
    expect_snap(2, 1, 1, 0, 1, 0);
    expect_snap(1, 1, 0, 0, 1, 0);
    expect_snap(1, 2, 0, 0, 1, 0);
    expect_snap(1, 2, 0, 0, 0, 0);
    trig(1);
    step(240);
    // A hit at hp 1 is fatal.
    expect_snap(0, 2, 0, 1, 0, 1);
    expect_snap(0, 3, 0, 0, 0, 1);
    trig(1);
    step(5);
    expect_snap(92, 92, 0, 0, 0, 0);
    expect_snap(92, 0, 0, 0, 0, 0);
    reload(92);
    step(5);
`else
    // Reload to the same width: nothing moves.
    reload(92);
    step(3);
    // Trigger held 3 cycles: exactly one hit.
    expect_snap(82, 0, 0, 1, 1, 0);
    expect_snap(82, 10, 0, 0, 1, 0);
    expect_snap(82, 10, 0, 0, 0, 0);
    trig(3);
    step(230);
    // Trigger held across the invulnerability window re-hits once alive.
    expect_snap(72, 10, 0, 1, 1, 0);
    expect_snap(72, 20, 0, 0, 1, 0);
    expect_snap(72, 20, 0, 0, 0, 0);
    expect_snap(62, 20, 0, 1, 1, 0);
    expect_snap(62, 30, 0, 0, 1, 0);
    expect_snap(62, 30, 0, 0, 0, 0);
    trig(260);
    step(250);
    // Lethal hit, ignored trigger while dead, reload back to life.
    expect_snap(5, 0, 0, 0, 0, 0);
    reload(5);
    healt_bar_sensitivity = 7'd7;
    expect_snap(0, 0, 0, 1, 0, 1);
    expect_snap(0, 5, 0, 0, 0, 1);
    trig(1);
    step(5);
    trig(3);
    step(5);
    expect_snap(92, 92, 0, 0, 0, 0);
    expect_snap(92, 0, 0, 0, 0, 0);
    reload(92);
    step(5);
    // Reload and trigger together: reload wins, no hit.
    expect_snap(50, 0, 0, 0, 0, 0);
    reload(50);
    step(3);
    expect_snap(70, 20, 0, 0, 0, 0);
    expect_snap(70, 0, 0, 0, 0, 0);
    healt_bar_w = 10'd70;
    reset_healt_status = 1'b1;
    is_trigger_player = 1'b1;
    step(1);
    reset_healt_status = 1'b0;
    is_trigger_player = 1'b0;
    step(5);
    expect_snap(63, 0, 0, 1, 1, 0);
    expect_snap(63, 7, 0, 0, 1, 0);
    expect_snap(63, 7, 0, 0, 0, 0);
    trig(1);
    step(230);
    // Zero damage still counts as a hit.
    healt_bar_sensitivity = 7'd0;
    expect_snap(63, 7, 0, 1, 1, 0);
    expect_snap(63, 7, 0, 0, 1, 0);
    expect_snap(63, 7, 0, 0, 0, 0);
    trig(1);
    step(230);
    // Asynchronous reset in the middle of invulnerability.
    healt_bar_sensitivity = 7'd7;
    expect_snap(56, 7, 0, 1, 1, 0);
    expect_snap(56, 14, 0, 0, 1, 0);
    trig(1);
    step(20);
    expect_snap(92, 0, 0, 0, 0, 0);
    #2;
    clk_reset_n = 1'b0;
    #1;
    tests++;
    if (hp !== 10'd92 || player_hurt !== 1'b0 || healt_bar_w_minus !== 10'd0) begin
      fails++;
      $display("FAIL async_reset got hp=%0d hurt=%b minus=%0d required hp=92 hurt=0 minus=0",
               hp, player_hurt, healt_bar_w_minus);
    end
    step(3);
    clk_reset_n = 1'b1;
    step(5);
    // Reload with zero width lands in DEAD.
    expect_snap(0, 0, 0, 0, 0, 1);
    reload(0);
    step(5);
    trig(2);
    step(5);
    expect_snap(92, 92, 0, 0, 0, 0);
    expect_snap(92, 0, 0, 0, 0, 0);
    reload(92);
    step(5);
`endif
    step(5);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_outputs got %0d expected snapshots never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
